// File: rtl/aes_sbox_arbiter.sv
// rtl/aes_sbox_arbiter.sv - shares one SubBytes instance between the round datapath and the key scheduler.
// Optional macro SBOX_PIPE_EN adds a tagged register stage after sb_out (2-cycle latency).
`timescale 1ns/1ps
module aes_sbox_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_rsp_data,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  output logic [1:0]   grant_id
);

  logic         st_elig, key_elig;
  logic         st_grant, key_grant;
  logic         last_key;
  logic         st_cap, key_cap;
  logic [127:0] cap_data;

`ifdef SBOX_PIPE_EN
  logic         pipe_valid, pipe_tag;
  logic [127:0] pipe_data;

  // pipe_tag = 1 marks a key transaction in the stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_tag   <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= st_grant | key_grant;
      pipe_tag   <= key_grant;
      pipe_data  <= sb_out;
    end
  end

  assign st_elig  = st_req_valid && (!st_rsp_valid || st_rsp_ready) && !(pipe_valid && !pipe_tag);
  assign key_elig = key_req_valid && (!key_rsp_valid || key_rsp_ready) && !(pipe_valid && pipe_tag);
  assign st_cap   = pipe_valid && !pipe_tag;
  assign key_cap  = pipe_valid && pipe_tag;
  assign cap_data = pipe_data;
`else
  assign st_elig  = st_req_valid && (!st_rsp_valid || st_rsp_ready);
  assign key_elig = key_req_valid && (!key_rsp_valid || key_rsp_ready);
  assign st_cap   = st_grant;
  assign key_cap  = key_grant;
  assign cap_data = sb_out;
`endif

  always_comb begin
    st_grant  = 1'b0;
    key_grant = 1'b0;
    if (!rst) begin
      if (st_elig && key_elig) begin
        if (ARB_MODE == 1) key_grant = 1'b1;
        else if (last_key) st_grant = 1'b1;
        else key_grant = 1'b1;
      end else begin
        st_grant  = st_elig;
        key_grant = key_elig;
      end
    end
  end

  assign st_req_ready  = st_grant;
  assign key_req_ready = key_grant;
  assign grant_id      = {key_grant, st_grant};
  assign sb_in         = st_grant  ? st_req_data :
                         key_grant ? {96'h0, key_req_data} : 128'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_key      <= 1'b1;
      st_rsp_valid  <= 1'b0;
      st_rsp_data   <= '0;
      key_rsp_valid <= 1'b0;
      key_rsp_data  <= '0;
    end else begin
      if (st_grant || key_grant) last_key <= key_grant;
      // a capture overrides a drain so back-to-back results keep valid high
      if (st_cap) begin
        st_rsp_valid <= 1'b1;
        st_rsp_data  <= cap_data;
      end else if (st_rsp_ready) begin
        st_rsp_valid <= 1'b0;
      end
      if (key_cap) begin
        key_rsp_valid <= 1'b1;
        key_rsp_data  <= cap_data[31:0];
      end else if (key_rsp_ready) begin
        key_rsp_valid <= 1'b0;
      end
    end
  end

endmodule
